hdmi_packet_assembler: RTL and testbench

Serializes one HDMI data-island packet (24-bit header plus four 56-bit subpackets) into 32 consecutive 9-bit pixel-clock words, with BCH ECC parity generated on the fly. It sits between the packet source/picker and the TERC4 channel encoders in the HDMI transmitter. Module name: `hdmi_packet_assembler`.

---
 rtl/hdmi_packet_assembler_pkg.sv | 19 +
 rtl/hdmi_packet_assembler.sv | 83 ++++++++
 tb/tb_hdmi_packet_assembler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_assembler_pkg.sv
// Shared HDMI definitions for the data-island path.
// Contents:
//   - BCH ECC polynomial constant
//   - next_ecc: one bit step of the BCH parity generator
//   - packet length and header/subpacket data widths
package hdmi_packet_assembler_pkg;

    localparam logic [7:0] ECC_POLY   = 8'h83;
    localparam int         PACKET_LEN = 32;
    localparam int         HEADER_W   = 24;
    localparam int         SUB_W      = 56;

    // Shift the parity right by one and fold in the polynomial whenever the
    // outgoing parity bit disagrees with the incoming data bit.
    function automatic logic [7:0] next_ecc(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_packet_assembler.sv
// Serializes one HDMI data-island packet (24-bit header + four 56-bit
// subpackets) into 32 consecutive 9-bit words, generating the BCH parity of
// every lane on the fly and emitting it in the tail of the packet.
// Ports:
//   clk_pixel          - pixel clock
//   reset              - synchronous, active-high
//   data_island_period - high while packet words are being sent
//   header             - HB2:HB0, HB0 in [7:0]
//   sub[3:0]           - subpackets 0..3, byte 0 in [7:0]
//   packet_data        - current 9-bit word (combinational from counter/inputs)
//   packet_enable      - asks the source for the next packet
//   counter            - word position within the packet, 0..31
module hdmi_packet_assembler
    import hdmi_packet_assembler_pkg::*;
(
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic                data_island_period,
    input  logic [HEADER_W-1:0] header,
    input  logic [SUB_W-1:0]    sub [3:0],
    output logic [8:0]          packet_data,
    output logic                packet_enable,
    output logic [4:0]          counter
);

    // Lanes 0..3 cover the subpackets, lane 4 covers the header.
    logic [7:0]  parity [4:0];
    logic [31:0] bch4;
    logic [63:0] bch [3:0];
    logic [5:0]  bit_even;
    logic [5:0]  bit_odd;
    logic        packet_last;
    logic        lane_clear;

    assign bit_even      = {counter, 1'b0};
    assign bit_odd       = {counter, 1'b1};
    assign packet_last   = (counter == 5'(PACKET_LEN - 1));
    // Parity restarts on reset, on abort, and after the final word.
    assign lane_clear    = reset || !data_island_period || packet_last;
    assign packet_enable = data_island_period && (counter == 5'd0);

    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period) begin
            counter <= 5'd0;
        end else begin
            counter <= counter + 5'd1;   // wraps 31 -> 0 for back-to-back packets
        end
    end

    // Once the data bits of a lane are exhausted the parity is held, so the
    // upper index range of each bch word streams out the finished ECC.
    assign bch4           = {parity[4], header};
    assign packet_data[0] = bch4[counter];

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_lane
            if (gi == 4) begin : g_header
                always_ff @(posedge clk_pixel) begin
                    if (lane_clear) begin
                        parity[gi] <= 8'h00;
                    end else if (counter < 5'(HEADER_W)) begin
                        parity[gi] <= next_ecc(parity[gi], header[counter]);
                    end
                end
            end else begin : g_sub
                // Two subpacket bits per word, so two ECC steps per clock.
                always_ff @(posedge clk_pixel) begin
                    if (lane_clear) begin
                        parity[gi] <= 8'h00;
                    end else if (counter < 5'(SUB_W / 2)) begin
                        parity[gi] <= next_ecc(next_ecc(parity[gi], sub[gi][bit_even]),
                                               sub[gi][bit_odd]);
                    end
                end

                assign bch[gi]              = {parity[gi], sub[gi]};
                assign packet_data[1 + gi]  = bch[gi][bit_even];
                assign packet_data[5 + gi]  = bch[gi][bit_odd];
            end
        end
    endgenerate

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
// Directed bench for hdmi_packet_assembler: header/subpacket ECC, counter
// tracking, bit interleave, abort and mid-packet reset.
module tb_hdmi_packet_assembler;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        data_island_period;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic [8:0]  packet_data;
    logic        packet_enable;
    logic [4:0]  counter;

    int checks = 0;
    int errors = 0;

    hdmi_packet_assembler dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .packet_enable      (packet_enable),
        .counter            (counter)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one full island, checking counter and packet_enable at every index.
    task automatic run_island(input string name);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s counter[%0d]", name, k), 64'(counter), 64'(k));
            check($sformatf("%s enable[%0d]", name, k), 64'(packet_enable), 64'(k == 0));
            step();
        end
    endtask

    task automatic run_idle(input string name);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s idle counter[%0d]", name, k), 64'(counter), 64'd0);
            check($sformatf("%s idle enable[%0d]", name, k), 64'(packet_enable), 64'd0);
            step();
        end
    endtask

    logic [7:0] hdr_ecc_bits;

    initial begin
        reset = 1'b1;
        data_island_period = 1'b1;
        header = 24'h000001;
        for (int i = 0; i < 4; i++) sub[i] = '0;
        #1;
        step();
        step();

        // Reset state; reset wins over data_island_period
        check("reset counter", 64'(counter), 64'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("reset parity[%0d]", i), 64'(dut.parity[i]), 64'd0);
        check("reset pd raw bit0", 64'(packet_data), 64'h001);
        check("reset enable follows dip", 64'(packet_enable), 64'd1);
        data_island_period = 1'b0;
        #1;
        check("reset enable low", 64'(packet_enable), 64'd0);
        reset = 1'b0;
        step();

        // Header ECC
        header = 24'h0D0282;
        data_island_period = 1'b1;
        #1;
        hdr_ecc_bits = '0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("hdr counter[%0d]", k), 64'(counter), 64'(k));
            if (k >= 24) hdr_ecc_bits[k - 24] = packet_data[0];
            if (k == 31) begin
                check("hdr parity4", 64'(dut.parity[4]), 64'hE4);
                for (int i = 0; i < 4; i++)
                    check($sformatf("hdr parity[%0d]", i), 64'(dut.parity[i]), 64'd0);
            end
            step();
        end
        check("hdr ecc stream", 64'(hdr_ecc_bits), 64'hE4);
        // Back-to-back: wrapped, parity cleared, enable pulses again
        check("b2b counter", 64'(counter), 64'd0);
        check("b2b parity4 cleared", 64'(dut.parity[4]), 64'd0);
        check("b2b enable", 64'(packet_enable), 64'd1);

        // Subpacket ECC
        header = 24'h0;
        sub[0] = 56'h402F;
        #1;
        for (int k = 0; k < 32; k++) begin
            if (k == 31) begin
                check("sub parity0", 64'(dut.parity[0]), 64'h71);
                for (int i = 1; i < 5; i++)
                    check($sformatf("sub parity[%0d]", i), 64'(dut.parity[i]), 64'd0);
            end
            step();
        end

        // Bit interleave
        sub[0] = '0;
        sub[2] = 56'h1;
        #1;
        for (int k = 0; k < 28; k++) begin
            if (k == 0) begin
                check("ilv pd c0", 64'(packet_data), 64'h008);
            end else begin
                check($sformatf("ilv pd3[%0d]", k), 64'(packet_data[3]), 64'd0);
                check($sformatf("ilv pd7[%0d]", k), 64'(packet_data[7]), 64'd0);
                if (k < 24) check($sformatf("ilv pd[%0d]", k), 64'(packet_data), 64'd0);
            end
            step();
        end
        sub[2] = '0;
        data_island_period = 1'b0;
        step();

        // Counter tracking: islands separated by idle gaps
        run_idle("trk0");
        data_island_period = 1'b1;
        #1;
        run_island("trk1");
        data_island_period = 1'b0;
        #1;
        run_idle("trk1");
        data_island_period = 1'b1;
        #1;
        run_island("trk2");
        data_island_period = 1'b0;
        step();

        // Abort at c = 10
        header = 24'h0D0282;
        data_island_period = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) step();
        check("abort counter pre", 64'(counter), 64'd10);
        check("abort parity4 pre", 64'(dut.parity[4]), 64'h0D);
        data_island_period = 1'b0;
        step();
        check("abort counter", 64'(counter), 64'd0);
        check("abort parity4", 64'(dut.parity[4]), 64'd0);
        data_island_period = 1'b1;
        #1;
        for (int k = 0; k < 31; k++) step();
        check("abort recount", 64'(counter), 64'd31);
        check("abort recomputed ecc", 64'(dut.parity[4]), 64'hE4);
        step();

        // Reset mid-packet at c = 15
        sub[0] = 56'h402F;
        #1;
        for (int k = 0; k < 15; k++) step();
        check("rst mid counter pre", 64'(counter), 64'd15);
        check("rst mid parity0 live", 64'(dut.parity[0] != 8'h00), 64'd1);
        reset = 1'b1;
        step();
        check("rst mid counter", 64'(counter), 64'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("rst mid parity[%0d]", i), 64'(dut.parity[i]), 64'd0);
        reset = 1'b0;
        data_island_period = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
